// File: rtl/crc_param_engine.sv
// ---------------------------------------------------------------------------
// crc_param_engine
//
// Generic serial/parallel CRC engine. Accepts one DATA_WIDTH word per
// valid/ready handshake and folds it into the running CRC register,
// BITS_PER_CYCLE bits per clock, over DATA_WIDTH/BITS_PER_CYCLE clocks.
// A one-cycle o_CRC_Ready pulse marks the end of each word.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   i_Init       reseed CRC register to INIT / abort a word in progress
//   i_Valid      input word valid
//   o_Ready      engine can accept a word (registered, high only in IDLE)
//   i_Data       input word
//   o_CRC        raw CRC register
//   o_CRC_Final  (REFLECT_OUT ? reverse(o_CRC) : o_CRC) ^ XOR_OUT
//   o_CRC_Ready  one-cycle pulse: word fully folded
//   o_Busy       high while a word is being folded
// ---------------------------------------------------------------------------
module crc_param_engine #(
    parameter int                   CRC_WIDTH      = 32,
    parameter logic [CRC_WIDTH-1:0] POLY           = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT           = 32'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT        = 32'hFFFFFFFF,
    parameter bit                   REFLECT_IN     = 1'b1,
    parameter bit                   REFLECT_OUT    = 1'b1,
    parameter int                   DATA_WIDTH     = 8,
    parameter int                   BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_Init,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic [CRC_WIDTH-1:0]  o_CRC,
    output logic [CRC_WIDTH-1:0]  o_CRC_Final,
    output logic                  o_CRC_Ready,
    output logic                  o_Busy
);

    localparam int STEPS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // A word width that is not a whole number of fold steps cannot be
    // sequenced by the step counter, so refuse to build it.
    if (DATA_WIDTH % BITS_PER_CYCLE != 0) begin : g_width_check
        $error("crc_param_engine: DATA_WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    logic [0:0]            state;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [CNT_W-1:0]      step_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  ready_reg;
    logic                  crc_ready_reg;

    logic [DATA_WIDTH-1:0] data_in;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [CRC_WIDTH-1:0]  crc_view;

    // Reflected input means the word arrives LSB first on the line; reversing
    // it once at accept time lets the fold always consume the MSB first.
    always_comb begin
        data_in = i_Data;
        if (REFLECT_IN) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                data_in[i] = i_Data[DATA_WIDTH-1-i];
            end
        end
    end

    // Fold the top BITS_PER_CYCLE bits of the shift register into the CRC,
    // one bit after another, all within a single clock.
    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (crc_next[CRC_WIDTH-1] ^ shift_reg[DATA_WIDTH-1-i]) begin
                crc_next = {crc_next[CRC_WIDTH-2:0], 1'b0} ^ POLY;
            end else begin
                crc_next = {crc_next[CRC_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Handshake, step sequencing and CRC register update. i_Init has
    // priority over folding while in SHIFT and aborts the word silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            crc_reg       <= INIT;
            step_cnt      <= '0;
            shift_reg     <= '0;
            ready_reg     <= 1'b1;
            crc_ready_reg <= 1'b0;
        end else begin
            crc_ready_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Valid && ready_reg) begin
                        shift_reg <= data_in;
                        step_cnt  <= CNT_LAST;
                        state     <= ST_SHIFT;
                        ready_reg <= 1'b0;
                        if (i_Init) begin
                            crc_reg <= INIT;
                        end
                    end else if (i_Init) begin
                        crc_reg <= INIT;
                    end
                end
                ST_SHIFT: begin
                    if (i_Init) begin
                        crc_reg   <= INIT;
                        state     <= ST_IDLE;
                        step_cnt  <= '0;
                        shift_reg <= '0;
                        ready_reg <= 1'b1;
                    end else begin
                        crc_reg   <= crc_next;
                        shift_reg <= shift_reg << BITS_PER_CYCLE;
                        if (step_cnt == '0) begin
                            state         <= ST_IDLE;
                            ready_reg     <= 1'b1;
                            crc_ready_reg <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Output view of the register: optional bit reversal before XOR_OUT.
    always_comb begin
        crc_view = crc_reg;
        if (REFLECT_OUT) begin
            for (int i = 0; i < CRC_WIDTH; i++) begin
                crc_view[i] = crc_reg[CRC_WIDTH-1-i];
            end
        end
    end

    assign o_CRC       = crc_reg;
    assign o_CRC_Final = crc_view ^ XOR_OUT;
    assign o_Ready     = ready_reg;
    assign o_CRC_Ready = crc_ready_reg;
    assign o_Busy      = (state == ST_SHIFT);

endmodule

// File: tb/tb_crc_param_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_param_engine
//
// Drives two engines: instance 0 with the default CRC-32 setup folding one
// bit per clock, instance 1 configured as CRC-32/MPEG-2 folding a whole byte
// per clock. Expected CRCs come from byte-wise lookup tables built from the
// polynomials, independent of the engine's bit-serial structure.
// ---------------------------------------------------------------------------
module tb_crc_param_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        init_s      [2];
    logic        valid_s     [2];
    logic [7:0]  data_s      [2];
    logic        ready_s     [2];
    logic        crc_ready_s [2];
    logic        busy_s      [2];
    logic [31:0] crc_s       [2];
    logic [31:0] final_s     [2];

    crc_param_engine dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_Init      (init_s[0]),
        .i_Valid     (valid_s[0]),
        .o_Ready     (ready_s[0]),
        .i_Data      (data_s[0]),
        .o_CRC       (crc_s[0]),
        .o_CRC_Final (final_s[0]),
        .o_CRC_Ready (crc_ready_s[0]),
        .o_Busy      (busy_s[0])
    );

    crc_param_engine #(
        .XOR_OUT        (32'h0),
        .REFLECT_IN     (1'b0),
        .REFLECT_OUT    (1'b0),
        .BITS_PER_CYCLE (8)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_Init      (init_s[1]),
        .i_Valid     (valid_s[1]),
        .o_Ready     (ready_s[1]),
        .i_Data      (data_s[1]),
        .o_CRC       (crc_s[1]),
        .o_CRC_Final (final_s[1]),
        .o_CRC_Ready (crc_ready_s[1]),
        .o_Busy      (busy_s[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: instance 0 is tracked in the reflected domain,
    // instance 1 in the normal domain.
    logic [31:0] tbl_r [256];
    logic [31:0] tbl_n [256];
    logic [31:0] refl_crc;
    logic [31:0] norm_crc;

    typedef struct {
        int          len;
        logic [71:0] bytes;
        bit          with_init;
        logic [31:0] exp_a;
        bit          has_b;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic int stepsOf(input int sel);
        return (sel == 0) ? 8 : 1;
    endfunction

    task automatic buildTables();
        logic [31:0] r;
        logic [31:0] n;
        for (int i = 0; i < 256; i++) begin
            r = 32'(i);
            n = 32'(i) << 24;
            for (int b = 0; b < 8; b++) begin
                r = r[0]  ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
                n = n[31] ? ((n << 1) ^ 32'h04C11DB7) : (n << 1);
            end
            tbl_r[i] = r;
            tbl_n[i] = n;
        end
    endtask

    task automatic modelInit(input int sel);
        if (sel == 0) refl_crc = 32'hFFFFFFFF;
        else          norm_crc = 32'hFFFFFFFF;
    endtask

    task automatic modelFold(input int sel, input logic [7:0] d);
        if (sel == 0) refl_crc = (refl_crc >> 8) ^ tbl_r[refl_crc[7:0] ^ d];
        else          norm_crc = (norm_crc << 8) ^ tbl_n[norm_crc[31:24] ^ d];
    endtask

    function automatic logic [31:0] modelRaw(input int sel);
        return (sel == 0) ? rev32(refl_crc) : norm_crc;
    endfunction

    function automatic logic [31:0] modelFinal(input int sel);
        return (sel == 0) ? (refl_crc ^ 32'hFFFFFFFF) : norm_crc;
    endfunction

    // Standalone reseed while idle: register returns to INIT with no pulse.
    task automatic doInit(input int sel);
        init_s[sel] = 1'b1;
        @(negedge clk);
        init_s[sel] = 1'b0;
        modelInit(sel);
        checkOutput("init_raw", crc_s[sel], modelRaw(sel));
        checkOutput("init_no_pulse", crc_ready_s[sel], 1'b0);
    endtask

    // Send one byte and follow it through to its completion pulse.
    task automatic applyStimulus(input int sel, input logic [7:0] d, input bit with_init);
        int guard = 0;
        int shifts = 0;
        bit saw_ready = 1'b0;
        bit busy_bad = 1'b0;
        while (!ready_s[sel] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_send", ready_s[sel], 1'b1);
        valid_s[sel] = 1'b1;
        data_s[sel]  = d;
        init_s[sel]  = with_init;
        @(negedge clk);
        valid_s[sel] = 1'b0;
        init_s[sel]  = 1'b0;
        data_s[sel]  = 8'($urandom);
        if (with_init) modelInit(sel);
        modelFold(sel, d);
        while (!crc_ready_s[sel] && shifts < 64) begin
            if (ready_s[sel]) saw_ready = 1'b1;
            if (!busy_s[sel]) busy_bad = 1'b1;
            @(negedge clk);
            shifts++;
        end
        checkOutput("pulse_latency", 64'(shifts), 64'(stepsOf(sel)));
        checkOutput("ready_low_in_shift", saw_ready, 1'b0);
        checkOutput("busy_high_in_shift", busy_bad, 1'b0);
        checkOutput("ready_at_pulse", ready_s[sel], 1'b1);
        checkOutput("busy_at_pulse", busy_s[sel], 1'b0);
        checkOutput("crc_raw", crc_s[sel], modelRaw(sel));
        checkOutput("crc_final", final_s[sel], modelFinal(sel));
        @(negedge clk);
        checkOutput("pulse_width", crc_ready_s[sel], 1'b0);
        checkOutput("crc_stable_idle", crc_s[sel], modelRaw(sel));
    endtask

    logic [71:0] msg = "123456789";

    initial begin
        int n;
        int idx;
        int pulses;
        logic [7:0] b;

        buildTables();
        vecs[0] = '{9, 72'h313233343536373839, 1'b0, 32'hCBF43926, 1'b1, 32'h0376E6E7};
        vecs[1] = '{9, 72'h313233343536373839, 1'b1, 32'hCBF43926, 1'b1, 32'h0376E6E7};
        vecs[2] = '{1, 72'h00,                 1'b0, 32'hD202EF8D, 1'b0, 32'h0};
        vecs[3] = '{1, 72'h00,                 1'b1, 32'hD202EF8D, 1'b0, 32'h0};
        vecs[4] = '{1, 72'h61,                 1'b0, 32'hE8B7BE43, 1'b0, 32'h0};
        vecs[5] = '{3, 72'h616263,             1'b1, 32'h352441C2, 1'b0, 32'h0};

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            init_s[s]  = 1'b0;
            valid_s[s] = 1'b0;
            data_s[s]  = 8'h00;
        end
        modelInit(0);
        modelInit(1);

        #2;
        checkOutput("reset_crc_a", crc_s[0], 32'hFFFFFFFF);
        checkOutput("reset_final_a", final_s[0], 32'h0);
        checkOutput("reset_final_b", final_s[1], 32'hFFFFFFFF);
        checkOutput("reset_ready_a", ready_s[0], 1'b1);
        checkOutput("reset_busy_a", busy_s[0], 1'b0);
        checkOutput("reset_pulse_a", crc_ready_s[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors on both configurations.
        for (int v = 0; v < 6; v++) begin
            for (int s = 0; s < 2; s++) begin
                if (!vecs[v].with_init) doInit(s);
                for (int i = 0; i < vecs[v].len; i++) begin
                    b = vecs[v].bytes[8*(vecs[v].len-1-i) +: 8];
                    applyStimulus(s, b, vecs[v].with_init && (i == 0));
                end
                if (s == 0)
                    checkOutput("vec_final_a", final_s[0], vecs[v].exp_a);
                else
                    checkOutput("vec_final_b", final_s[1],
                                vecs[v].has_b ? vecs[v].exp_b : modelFinal(1));
            end
        end

        // Abort a word with i_Init on its third shift edge.
        doInit(0);
        valid_s[0] = 1'b1;
        data_s[0]  = 8'hAA;
        @(negedge clk);
        valid_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        init_s[0] = 1'b1;
        @(negedge clk);
        init_s[0] = 1'b0;
        checkOutput("abort_no_pulse", crc_ready_s[0], 1'b0);
        checkOutput("abort_crc", crc_s[0], 32'hFFFFFFFF);
        checkOutput("abort_ready", ready_s[0], 1'b1);
        checkOutput("abort_busy", busy_s[0], 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (crc_ready_s[0]) pulses++;
        end
        checkOutput("abort_pulse_count", 64'(pulses), 64'd0);
        modelInit(0);
        applyStimulus(0, 8'h00, 1'b0);
        checkOutput("abort_then_zero", final_s[0], 32'hD202EF8D);

        // Asynchronous reset in the middle of a word.
        valid_s[0] = 1'b1;
        data_s[0]  = 8'h5A;
        @(negedge clk);
        valid_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy_before_rst", busy_s[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_crc", crc_s[0], 32'hFFFFFFFF);
        checkOutput("async_rst_ready", ready_s[0], 1'b1);
        checkOutput("async_rst_busy", busy_s[0], 1'b0);
        checkOutput("async_rst_pulse", crc_ready_s[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelInit(0);
        modelInit(1);
        @(negedge clk);
        for (int i = 0; i < 9; i++) applyStimulus(0, msg[8*(8-i) +: 8], 1'b0);
        checkOutput("after_rst_check", final_s[0], 32'hCBF43926);

        // i_Valid held high with junk data whenever o_Ready is low.
        doInit(0);
        n = 0;
        idx = 0;
        pulses = 0;
        valid_s[0] = 1'b1;
        while (n < 1000) begin
            if (crc_ready_s[0]) pulses++;
            if (ready_s[0]) begin
                if (idx == 9) break;
                b = msg[8*(8-idx) +: 8];
                data_s[0] = b;
                modelFold(0, b);
                idx++;
            end else begin
                data_s[0] = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        valid_s[0] = 1'b0;
        checkOutput("held_valid_cycles", 64'(n), 64'd81);
        checkOutput("held_valid_pulses", 64'(pulses), 64'd9);
        checkOutput("held_valid_final", final_s[0], 32'hCBF43926);
        checkOutput("held_valid_raw", crc_s[0], modelRaw(0));

        // Randomised words with occasional reseeds on both configurations.
        for (int s = 0; s < 2; s++) begin
            doInit(s);
            for (int w = 0; w < 40; w++) begin
                if ($urandom_range(0, 9) == 0) doInit(s);
                applyStimulus(s, 8'($urandom), $urandom_range(0, 7) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
